video_axis_packer: RTL and testbench

VIDEO_AXIS_PACKER -- requirements
Module: video_axis_packer

---
 rtl/video_axis_packer_if.sv | 10 +
 rtl/video_axis_packer.sv | 60 ++++++
 tb/tb_video_axis_packer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/video_axis_packer_if.sv
// video_axis_packer_if: AXI4-Stream RGB888 video beat with start-of-frame and end-of-line sidebands
interface video_axis_packer_if;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;
  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/video_axis_packer.sv
// video_axis_packer: frame-locked RGB444 to AXI4-Stream RGB888 packer behind a first-word-fall-through FIFO
module video_axis_packer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 pixel_clk,
  input  logic                 reset,
  input  logic [9:0]           pixel_x,
  input  logic [9:0]           pixel_y,
  input  logic                 video_on,
  input  logic [11:0]          rgb_in,
  video_axis_packer_if.master  axis,
  output logic                 overflow,
  output logic [15:0]          frame_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  if (FIFO_DEPTH < 4 || (1 << AW) != FIFO_DEPTH || H_ACTIVE < 1 || H_ACTIVE > 1024 ||
      V_ACTIVE < 1 || V_ACTIVE > 1024) begin : g_bad_params
    $error("video_axis_packer: illegal parameters");
  end
  typedef enum logic [1:0] {SYNC, RUN, DROP} state_t;
  state_t          state;
  logic [25:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            sof, eol, full, wr_en, pop;
  logic [25:0]     word;
  always_comb begin
    sof   = pixel_x == 10'd0 && pixel_y == 10'd0;
    eol   = pixel_x == 10'(H_ACTIVE - 1);
    full  = count == (AW + 1)'(FIFO_DEPTH);
    word  = {sof, eol, {2{rgb_in[11:8]}}, {2{rgb_in[3:0]}}, {2{rgb_in[7:4]}}};
    wr_en = video_on && !full && (state == RUN || sof);
    pop   = axis.tvalid && axis.tready;
  end
  assign axis.tvalid = count != '0;
  // Gate the head word so outputs read zero while empty, including right after reset.
  assign {axis.tuser, axis.tlast, axis.tdata} = axis.tvalid ? mem[rd_ptr] : 26'd0;
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state       <= SYNC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      frame_count <= '0;
    end else begin
      if (video_on) state <= wr_en ? RUN : (state == RUN ? DROP : state);
      if (video_on && state == RUN && full) overflow <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(wr_en) - (AW + 1)'(pop);
      if (pop && axis.tuser) frame_count <= frame_count + 16'd1;
    end
  end
  always_ff @(posedge pixel_clk) begin
    if (wr_en && !reset) mem[wr_ptr] <= word;
  end
endmodule

// File: tb/tb_video_axis_packer.sv
// tb_video_axis_packer: raster-driven random stimulus against a queue-based reference of the packer
module tb_video_axis_packer;
  localparam int H  = 24;
  localparam int V  = 4;
  localparam int D  = 16;
  localparam int HT = H + 4;
  localparam int VT = V + 1;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on;
  logic [11:0] rgb_in;
  logic        overflow;
  logic [15:0] frame_count;
  video_axis_packer_if axis ();
  video_axis_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)) dut (
    .pixel_clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .rgb_in(rgb_in), .axis(axis),
    .overflow(overflow), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  int          tests = 0;
  int          fails = 0;
  int          hx = 0;
  int          vy = 0;
  logic [25:0] q[$];
  bit          synced = 0;
  logic        ovf_m = 1'b0;
  logic [15:0] fc_m = 16'd0;
  task automatic chk_all();
    tests++;
    assert (axis.tvalid === (q.size() != 0)) else begin
      fails++; $error("FAIL tvalid got %b expected %b", axis.tvalid, q.size() != 0);
    end
    if (q.size() != 0) begin
      tests++;
      assert ({axis.tuser, axis.tlast, axis.tdata} === q[0]) else begin
        fails++; $error("FAIL beat got %h expected %h", {axis.tuser, axis.tlast, axis.tdata}, q[0]);
      end
    end
    tests++;
    assert (overflow === ovf_m) else begin
      fails++; $error("FAIL overflow got %b expected %b", overflow, ovf_m);
    end
    tests++;
    assert (frame_count === fc_m) else begin
      fails++; $error("FAIL frame_count got %0d expected %0d", frame_count, fc_m);
    end
  endtask
  task automatic cyc(input logic rdy, input logic rst_v);
    logic [11:0] c;
    logic        von, sof, push, full;
    logic [25:0] w;
    int          r, g, b;
    chk_all();
    c   = 12'($urandom);
    von = hx < H && vy < V;
    sof = hx == 0 && vy == 0;
    reset = rst_v; pixel_x = 10'(hx); pixel_y = 10'(vy); video_on = von; rgb_in = c; axis.tready = rdy;
    r = c[11:8] * 17; g = c[7:4] * 17; b = c[3:0] * 17;
    w = {sof, logic'(hx == H - 1), 24'(r * 65536 + b * 256 + g)};
    push = 1'b0;
    if (rst_v) begin
      q.delete(); synced = 0; ovf_m = 1'b0; fc_m = 16'd0;
    end else begin
      full = q.size() == D;
      if (von) begin
        if (!synced) begin
          if (sof && !full) begin push = 1'b1; synced = 1; end
        end else if (full) begin
          ovf_m = 1'b1; synced = 0;
        end else push = 1'b1;
      end
      if (q.size() != 0 && rdy) begin
        if (q[0][25]) fc_m = fc_m + 16'd1;
        void'(q.pop_front());
      end
      if (push) q.push_back(w);
    end
    hx++;
    if (hx == HT) begin hx = 0; vy = (vy + 1) % VT; end
    @(posedge clk); @(negedge clk);
  endtask
  task automatic run(input int n, input int mode);
    logic rdy;
    for (int i = 0; i < n; i++) begin
      rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : mode == 2 ? logic'($urandom % 2) : logic'(i % 2 == 0);
      cyc(rdy, 1'b0);
    end
  endtask
  task automatic align();
    while (!(hx == 0 && vy == 0)) cyc(1'b1, 1'b0);
  endtask
  initial begin
    reset = 1'b1; pixel_x = '0; pixel_y = '0; video_on = 1'b0; rgb_in = '0; axis.tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    repeat (3) cyc(1'b1, 1'b1);
    tests++;
    assert ({axis.tuser, axis.tlast, axis.tdata} === 26'd0) else begin
      fails++; $error("FAIL reset_outputs got %h expected 0", {axis.tuser, axis.tlast, axis.tdata});
    end
    hx = 5; vy = 1;
    run(HT * VT * 2, 0);
    run(HT * VT * 3, 2);
    align();
    run(20, 1);
    tests++;
    assert (overflow === 1'b1) else begin
      fails++; $error("FAIL overflow_set got %b expected 1", overflow);
    end
    run(HT * VT * 2, 0);
    run(HT * VT * 2, 3);
    align();
    run(5, 1);
    cyc(1'b0, 1'b1);
    tests++;
    assert ({axis.tvalid, overflow, frame_count} === 18'd0) else begin
      fails++; $error("FAIL reset_queued got %b/%b/%0d expected 0/0/0", axis.tvalid, overflow, frame_count);
    end
    hx = 9; vy = 2;
    run(HT * VT * 3, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
